// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  // Controller states; the encoding is fixed so it reads the same in waveforms.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of the nibble index counter, kept at least one bit wide.
  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// One 4-bit ripple adder slice, reused by the sequencer for every nibble.
module nibble_add4
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle, LSB nibble first,
// over a single shared 4-bit adder slice with a registered carry.
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_e                           state;
  logic [NIB-1:0][NIBBLE_W-1:0]     a_r;
  logic [NIB-1:0][NIBBLE_W-1:0]     b_r;     // already inverted for subtract
  logic [NIB-1:0][NIBBLE_W-1:0]     sum_r;
  logic                             carry;
  logic [IW-1:0]                    idx;
  logic                             cout_r;
  logic                             ovf_r;
  logic                             ov_r;

  logic [NIBBLE_W-1:0]              nib_s;
  logic                             nib_c;
  logic                             last;
  logic                             ovf_nxt;

  // The single adder slice sees whichever nibble idx currently selects.
  nibble_add4 u_add (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  assign last = (idx == IW'(NIB - 1));

  // Overflow uses the MSB being written this cycle, not the stale sum register.
  assign ovf_nxt = (a_r[NIB-1][NIBBLE_W-1] == b_r[NIB-1][NIBBLE_W-1]) &&
                   (nib_s[NIBBLE_W-1] != a_r[NIB-1][NIBBLE_W-1]);

  // Sequencer: accept in IDLE, one nibble per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      ov_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ov_r <= 1'b0;
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;            // +1 of the two's complement negate
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_r[idx] <= nib_s;
          carry      <= nib_c;
          idx        <= idx + IW'(1);
          if (last) begin
            cout_r <= nib_c;
            ovf_r  <= ovf_nxt;
            ov_r   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            ov_r  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = ov_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
